// File: rtl/cpc_mem_pkg.sv
// Shared types and widths for the CPC memory sequencer: FSM states, address widths and the
// byte-lane select helper.
package cpc_mem_pkg;

    localparam int unsigned CpuAddrW  = 23;
    localparam int unsigned WordAddrW = 22;
    localparam int unsigned VramAddrW = 15;
    // CPU slot payload: {we, wdata[7:0], byte address}
    localparam int unsigned CpuSlotW  = 1 + 8 + CpuAddrW;

    typedef enum logic [1:0] {
        StIdle,
        StVid,
        StCpu
    } seq_state_e;

    function automatic logic [7:0] sel_byte(input logic odd, input logic [15:0] word);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cpc_req_slot.sv
// One pending-request slot: latches a payload on set and holds it valid until cleared.
// A set in the same cycle as a clear wins, so a fresh request is never lost.
module cpc_req_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set,
    input  logic             i_clr,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    output logic [Width-1:0] o_data
);

    logic             r_valid;
    logic [Width-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/cpc_mem_sequencer.sv
// Arbitrates CPU byte accesses and video word fetches onto one 16-bit req/ack memory port.
// Optional feature macro: CPC_MEMSEQ_RDCACHE_EN adds a single-word CPU read cache.
module cpc_mem_sequencer
    import cpc_mem_pkg::*;
#(
    parameter logic [7:0] VRAM_BASE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CpuAddrW-1:0]  mem_addr,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [7:0]           mem_wdata,
    output logic [7:0]           mem_rdata,
    output logic                 cpu_busy,
    input  logic [VramAddrW-1:0] vram_addr,
    input  logic                 vram_req,
    output logic [15:0]          vram_din,
    output logic                 vram_valid,
    output logic                 vram_overrun,
    output logic [WordAddrW-1:0] ram_addr,
    output logic [15:0]          ram_wdata,
    output logic [1:0]           ram_be,
    output logic                 ram_we,
    output logic                 ram_req,
    input  logic                 ram_ack,
    input  logic [15:0]          ram_rdata
);

    seq_state_e r_state, w_state_next;

    logic                 r_mem_rd, r_mem_wr;
    logic                 w_rd_rise, w_wr_rise;
    logic                 w_cpu_set, w_cpu_valid;
    logic [CpuSlotW-1:0]  w_cpu_slot_in, w_cpu_data;
    logic                 w_cpu_we;
    logic [7:0]           w_cpu_wdata;
    logic [CpuAddrW-1:0]  w_cpu_addr;
    logic                 w_vid_valid;
    logic [VramAddrW-1:0] w_vid_addr;
    logic [WordAddrW-1:0] w_vid_word;
    logic                 w_launch_vid, w_launch_cpu, w_vid_done, w_cpu_done, w_cpu_hit;
    logic                 w_cache_hit;
    logic [15:0]          w_cache_rdata;

    logic [WordAddrW-1:0] r_ram_addr;
    logic [15:0]          r_ram_wdata;
    logic [1:0]           r_ram_be;
    logic                 r_ram_we;
    logic [7:0]           r_mem_rdata;
    logic [15:0]          r_vram_din;
    logic                 r_vram_valid;
    logic                 r_vram_overrun;

    assign w_rd_rise     = mem_rd & ~r_mem_rd;
    assign w_wr_rise     = mem_wr & ~r_mem_wr;
    // Simultaneous rd/wr edges resolve to a write; edges while busy are dropped.
    assign w_cpu_set     = (w_rd_rise | w_wr_rise) & ~w_cpu_valid;
    assign w_cpu_slot_in = {w_wr_rise, mem_wdata, mem_addr};

    assign w_cpu_we    = w_cpu_data[CpuSlotW-1];
    assign w_cpu_wdata = w_cpu_data[CpuAddrW+7:CpuAddrW];
    assign w_cpu_addr  = w_cpu_data[CpuAddrW-1:0];

    // VRAM_BASE is byte-address bits [22:15], i.e. word-address bits [21:14].
    assign w_vid_word = {VRAM_BASE, 14'b0} | {7'b0, w_vid_addr};

    cpc_req_slot #(
        .Width(CpuSlotW)
    ) u_cpu_slot (
        .clk    (clk),
        .reset  (reset),
        .i_set  (w_cpu_set),
        .i_clr  (w_cpu_done | w_cpu_hit),
        .i_data (w_cpu_slot_in),
        .o_valid(w_cpu_valid),
        .o_data (w_cpu_data)
    );

    // The video slot empties at launch so a request arriving mid-fetch queues behind it.
    cpc_req_slot #(
        .Width(VramAddrW)
    ) u_vid_slot (
        .clk    (clk),
        .reset  (reset),
        .i_set  (vram_req),
        .i_clr  (w_launch_vid),
        .i_data (vram_addr),
        .o_valid(w_vid_valid),
        .o_data (w_vid_addr)
    );

    always_comb begin
        w_state_next = r_state;
        w_launch_vid = 1'b0;
        w_launch_cpu = 1'b0;
        w_vid_done   = 1'b0;
        w_cpu_done   = 1'b0;
        w_cpu_hit    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_vid_valid) begin
                    w_state_next = StVid;
                    w_launch_vid = 1'b1;
                end else if (w_cpu_valid) begin
                    if (w_cache_hit) begin
                        w_cpu_hit = 1'b1;
                    end else begin
                        w_state_next = StCpu;
                        w_launch_cpu = 1'b1;
                    end
                end
            end
            StVid: begin
                if (ram_ack) begin
                    w_state_next = StIdle;
                    w_vid_done   = 1'b1;
                end
            end
            StCpu: begin
                if (ram_ack) begin
                    w_state_next = StIdle;
                    w_cpu_done   = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= 16'h0000;
            r_ram_be       <= 2'b00;
            r_ram_we       <= 1'b0;
            r_mem_rdata    <= 8'hFF;
            r_vram_din     <= 16'h0000;
            r_vram_valid   <= 1'b0;
            r_vram_overrun <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mem_rd     <= mem_rd;
            r_mem_wr     <= mem_wr;
            r_vram_valid <= w_vid_done;
            if (vram_req && (w_vid_valid || r_state == StVid)) begin
                r_vram_overrun <= 1'b1;
            end
            if (w_launch_vid) begin
                r_ram_addr <= w_vid_word;
                r_ram_be   <= 2'b11;
                r_ram_we   <= 1'b0;
            end
            if (w_launch_cpu) begin
                r_ram_addr  <= w_cpu_addr[CpuAddrW-1:1];
                r_ram_be    <= w_cpu_addr[0] ? 2'b10 : 2'b01;
                r_ram_we    <= w_cpu_we;
                r_ram_wdata <= {w_cpu_wdata, w_cpu_wdata};
            end
            if (w_vid_done) begin
                r_vram_din <= ram_rdata;
            end
            if (w_cpu_done && !w_cpu_we) begin
                r_mem_rdata <= sel_byte(w_cpu_addr[0], ram_rdata);
            end
            if (w_cpu_hit) begin
                r_mem_rdata <= sel_byte(w_cpu_addr[0], w_cache_rdata);
            end
        end
    end

`ifdef CPC_MEMSEQ_RDCACHE_EN
    logic                 r_cache_valid;
    logic [WordAddrW-1:0] r_cache_tag;
    logic [15:0]          r_cache_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
            r_cache_data  <= 16'h0000;
        end else if (w_cpu_done) begin
            if (!w_cpu_we) begin
                r_cache_valid <= 1'b1;
                r_cache_tag   <= w_cpu_addr[CpuAddrW-1:1];
                r_cache_data  <= ram_rdata;
            end else if (r_cache_tag == w_cpu_addr[CpuAddrW-1:1]) begin
                r_cache_valid <= 1'b0;
            end
        end
    end

    assign w_cache_hit   = r_cache_valid & ~w_cpu_we
                         & (r_cache_tag == w_cpu_addr[CpuAddrW-1:1]);
    assign w_cache_rdata = r_cache_data;
`else
    assign w_cache_hit   = 1'b0;
    assign w_cache_rdata = 16'h0000;
`endif

    assign ram_req      = (r_state != StIdle);
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign ram_be       = r_ram_be;
    assign ram_we       = r_ram_we;
    assign mem_rdata    = r_mem_rdata;
    assign cpu_busy     = w_cpu_valid;
    assign vram_din     = r_vram_din;
    assign vram_valid   = r_vram_valid;
    assign vram_overrun = r_vram_overrun;

endmodule

// File: tb/tb_cpc_mem_sequencer.sv
// Directed self-checking bench for cpc_mem_sequencer; the cache section follows
// CPC_MEMSEQ_RDCACHE_EN.
module tb_cpc_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        cpu_busy;
    logic [14:0] vram_addr;
    logic        vram_req;
    logic [15:0] vram_din;
    logic        vram_valid, vram_overrun;
    logic [21:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  ram_be;
    logic        ram_we, ram_req, ram_ack;
    logic [15:0] ram_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cpc_mem_sequencer u_dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .cpu_busy    (cpu_busy),
        .vram_addr   (vram_addr),
        .vram_req    (vram_req),
        .vram_din    (vram_din),
        .vram_valid  (vram_valid),
        .vram_overrun(vram_overrun),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_be      (ram_be),
        .ram_we      (ram_we),
        .ram_req     (ram_req),
        .ram_ack     (ram_ack),
        .ram_rdata   (ram_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_with(input logic [15:0] data);
        ram_ack   = 1'b1;
        ram_rdata = data;
        tick();
        ram_ack   = 1'b0;
    endtask

    // CPU read that acks any memory request with data; counts issued requests.
    task automatic cpu_read(input logic [22:0] a, input logic [15:0] data, inout int reqs);
        logic done;
        done     = 1'b0;
        mem_addr = a;
        mem_rd   = 1'b1;
        tick();
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            if (ram_req) begin
                reqs++;
                ack_with(data);
                done = 1'b1;
            end else if (!cpu_busy) begin
                done = 1'b1;
            end
        end
        check_eq("cpu_read_completes", {31'd0, done}, 32'd1);
        mem_rd = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        reset     = 1'b1;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        vram_addr = '0;
        vram_req  = 1'b0;
        ram_ack   = 1'b0;
        ram_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_eq("rst_ctl", {27'd0, ram_req, ram_we, vram_valid, vram_overrun, cpu_busy}, 32'd0);
        check_eq("rst_be", {30'd0, ram_be}, 32'd0);
        check_eq("rst_addr_wdata", {ram_addr[15:0], ram_wdata}, 32'd0);
        check_eq("rst_rdata_din", {8'd0, mem_rdata, vram_din}, 32'h00FF_0000);

        // CPU read of odd byte at 23'h004001
        mem_addr = 23'h00_4001;
        mem_rd   = 1'b1;
        tick();
        check_eq("rd_busy_ack_wait", {30'd0, cpu_busy, ram_req}, 32'b10);
        tick();
        check_eq("rd_req", {31'd0, ram_req}, 32'd1);
        check_eq("rd_addr", {10'd0, ram_addr}, 32'h0000_2000);
        check_eq("rd_be_we", {29'd0, ram_be, ram_we}, 32'b100);
        repeat (2) tick();
        check_eq("rd_req_held", {8'd0, ram_req, ram_addr, ram_be}, {8'd0, 1'b1, 22'h2000, 2'b10});
        ack_with(16'hA55A);
        check_eq("rd_done", {22'd0, ram_req, cpu_busy, mem_rdata}, 32'h0000_00A5);
        mem_rd = 1'b0;
        tick();

        // CPU write of 8'h3C to 23'h00C000
        mem_addr  = 23'h00_C000;
        mem_wdata = 8'h3C;
        mem_wr    = 1'b1;
        repeat (2) tick();
        check_eq("wr_req_we_be", {28'd0, ram_req, ram_we, ram_be}, 32'b1101);
        check_eq("wr_wdata", {16'd0, ram_wdata}, 32'h0000_3C3C);
        check_eq("wr_addr", {10'd0, ram_addr}, 32'h0000_6000);
        check_eq("wr_busy_before_ack", {31'd0, cpu_busy}, 32'd1);
        ack_with(16'h0000);
        check_eq("wr_busy_clear", {30'd0, cpu_busy, ram_req}, 32'd0);
        check_eq("wr_keeps_rdata", {24'd0, mem_rdata}, 32'h0000_00A5);
        mem_wr = 1'b0;
        tick();

        // Simultaneous video and CPU request: video first
        mem_addr  = 23'h00_0020;
        mem_rd    = 1'b1;
        vram_addr = 15'h1234;
        vram_req  = 1'b1;
        tick();
        vram_req = 1'b0;
        check_eq("both_idle_cycle", {31'd0, ram_req}, 32'd0);
        tick();
        check_eq("vid_first", {7'd0, ram_req, ram_be, ram_we, ram_addr},
                 {7'd0, 1'b1, 2'b11, 1'b0, 22'h001234});
        check_eq("vid_valid_pre", {31'd0, vram_valid}, 32'd0);
        tick();
        ack_with(16'hBEEF);
        check_eq("vid_done", {14'd0, ram_req, vram_valid, vram_din}, {14'd0, 1'b0, 1'b1, 16'hBEEF});
        tick();
        check_eq("cpu_after_vid", {7'd0, ram_req, vram_valid, ram_be, ram_addr},
                 {7'd0, 1'b1, 1'b0, 2'b01, 22'h000010});
        ack_with(16'h1234);
        check_eq("cpu_after_vid_data", {23'd0, vram_valid, mem_rdata}, 32'h0000_0034);
        mem_rd = 1'b0;
        tick();
        check_eq("no_overrun_yet", {31'd0, vram_overrun}, 32'd0);

        // Overrun: second request during an outstanding fetch
        vram_addr = 15'h0500;
        vram_req  = 1'b1;
        tick();
        vram_req = 1'b0;
        tick();
        check_eq("ovr_first_fetch", {9'd0, ram_req, ram_addr}, {9'd0, 1'b1, 22'h000500});
        vram_addr = 15'h0100;
        vram_req  = 1'b1;
        tick();
        vram_req = 1'b0;
        check_eq("ovr_flag", {31'd0, vram_overrun}, 32'd1);
        check_eq("ovr_addr_stable", {10'd0, ram_addr}, 32'h0000_0500);
        ack_with(16'h1111);
        check_eq("ovr_first_data", {15'd0, ram_req, vram_din}, 32'h0000_1111);
        tick();
        check_eq("ovr_second_fetch", {9'd0, ram_req, ram_addr}, {9'd0, 1'b1, 22'h000100});
        ack_with(16'h2222);
        check_eq("ovr_second_data", {15'd0, vram_valid, vram_din}, 32'h0001_2222);
        tick();
        check_eq("ovr_idle_sticky", {30'd0, ram_req, vram_overrun}, 32'b01);

        // Reset while a transaction is in flight, then a late ack
        mem_addr = 23'h00_0100;
        mem_rd   = 1'b1;
        repeat (2) tick();
        check_eq("inflight_req", {31'd0, ram_req}, 32'd1);
        reset  = 1'b1;
        mem_rd = 1'b0;
        tick();
        check_eq("inrst_ctl", {27'd0, ram_req, ram_we, vram_valid, vram_overrun, cpu_busy}, 32'd0);
        check_eq("inrst_data", {6'd0, ram_be, mem_rdata, vram_din}, 32'h00FF_0000);
        reset = 1'b0;
        tick();
        ack_with(16'hFFEE);
        check_eq("late_ack", {5'd0, ram_req, vram_valid, cpu_busy, mem_rdata, vram_din},
                 32'h00FF_0000);
        tick();
        check_eq("late_ack_idle", {31'd0, ram_req}, 32'd0);

        // Read cache behaviour (two reads of one word, then an invalidating write)
        reqs = 0;
        cpu_read(23'h00_0010, 16'hC3D4, reqs);
        check_eq("c_first_data", {24'd0, mem_rdata}, 32'h0000_00D4);
        cpu_read(23'h00_0010, 16'hC3D4, reqs);
        check_eq("c_second_data", {24'd0, mem_rdata}, 32'h0000_00D4);
`ifdef CPC_MEMSEQ_RDCACHE_EN
        check_eq("c_req_count", reqs, 32'd1);
`else
        check_eq("c_req_count", reqs, 32'd2);
`endif
        mem_addr  = 23'h00_0011;
        mem_wdata = 8'h77;
        mem_wr    = 1'b1;
        repeat (2) tick();
        check_eq("c_wr_req", {28'd0, ram_req, ram_we, ram_be}, 32'b1110);
        ack_with(16'h0000);
        mem_wr = 1'b0;
        tick();
        reqs = 0;
        cpu_read(23'h00_0010, 16'h5566, reqs);
        check_eq("c_after_wr_req", reqs, 32'd1);
        check_eq("c_after_wr_data", {24'd0, mem_rdata}, 32'h0000_0066);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
